// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline memory arbiter: word type, arbiter FSM states,
// latched request payload and the default timed-out load value.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    // Request latched when the arbiter leaves IDLE; drives the RAM during the access.
    typedef struct packed {
        word_t addr;
        word_t wdata;
        logic  wr;
    } mem_req_t;

    localparam word_t BAD_WORD_DFLT = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_timeout_counter.sv
// Watchdog for one RAM access: counts access cycles and flags the last
// allowed cycle so the arbiter can force an error completion.
module mem_timeout_counter
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Current access cycle is the last one allowed.
    assign expired_c = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// Single-port RAM arbiter between fetch (instruction) and memory (data) stages.
// Data requests win; one RAM access in flight; watchdog turns a hung access
// into an error completion with a sticky err flag.
// Optional one-entry fetch buffer: PIPELINE_MEM_ARBITER_IBUF_EN.
module pipeline_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 64,
    parameter word_t       BAD_WORD = BAD_WORD_DFLT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ram_REN,
    output logic        ram_WEN,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_ready,
    output logic        err
);

    arb_state_t state_q, state_d;
    mem_req_t   req_q, req_d;
    logic       ihit_q, ihit_d;
    logic       dhit_q, dhit_d;
    logic       ren_q, ren_d;
    logic       wen_q, wen_d;
    logic       err_q, err_d;
    word_t      iload_q, iload_d;
    word_t      dload_q, dload_d;

    logic       in_access_c;
    logic       expired_c;
    logic       buf_hit_c;
    word_t      buf_word_c;

    assign in_access_c = (state_q == DACC) || (state_q == IACC);

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .CLK       (CLK),
        .nRST      (nRST),
        .clr_i     (!in_access_c),
        .en_i      (in_access_c),
        .expired_c (expired_c)
    );

`ifdef PIPELINE_MEM_ARBITER_IBUF_EN
    logic  ibuf_vld_q, ibuf_vld_d;
    word_t ibuf_addr_q, ibuf_addr_d;
    word_t ibuf_data_q, ibuf_data_d;

    assign buf_hit_c  = ibuf_vld_q && (iaddr == ibuf_addr_q);
    assign buf_word_c = ibuf_data_q;

    // Buffer update: fill on good fetch, drop on aliasing write or any timeout.
    always_comb begin
        ibuf_vld_d  = ibuf_vld_q;
        ibuf_addr_d = ibuf_addr_q;
        ibuf_data_d = ibuf_data_q;
        if (state_q == IACC && ram_ready) begin
            ibuf_vld_d  = 1'b1;
            ibuf_addr_d = req_q.addr;
            ibuf_data_d = ram_load;
        end else if (state_q == DACC && ram_ready && req_q.wr && req_q.addr == ibuf_addr_q) begin
            ibuf_vld_d = 1'b0;
        end else if (expired_c && !ram_ready) begin
            ibuf_vld_d = 1'b0;
        end
    end

    // Buffer registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ibuf_vld_q  <= 1'b0;
            ibuf_addr_q <= '0;
            ibuf_data_q <= '0;
        end else begin
            ibuf_vld_q  <= ibuf_vld_d;
            ibuf_addr_q <= ibuf_addr_d;
            ibuf_data_q <= ibuf_data_d;
        end
    end
`else
    assign buf_hit_c  = 1'b0;
    assign buf_word_c = '0;
`endif

    // Arbitration FSM next state; hits and strobes are registered on entry to their state.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        ihit_d  = 1'b0;
        dhit_d  = 1'b0;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        err_d   = err_q;
        iload_d = iload_q;
        dload_d = dload_q;

        unique case (state_q)
            IDLE: begin
                if (dREN || dWEN) begin
                    // Read+write together is a write.
                    req_d   = '{addr: daddr, wdata: dstore, wr: dWEN};
                    ren_d   = !dWEN;
                    wen_d   = dWEN;
                    state_d = DACC;
                end else if (iREN) begin
                    if (buf_hit_c) begin
                        iload_d = buf_word_c;
                        ihit_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        req_d   = '{addr: iaddr, wdata: req_q.wdata, wr: 1'b0};
                        ren_d   = 1'b1;
                        state_d = IACC;
                    end
                end
            end

            DACC: begin
                ren_d = !req_q.wr;
                wen_d = req_q.wr;
                if (ram_ready) begin
                    if (!req_q.wr) begin
                        dload_d = ram_load;
                    end
                    dhit_d  = 1'b1;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    state_d = DONE;
                end else if (expired_c) begin
                    if (!req_q.wr) begin
                        dload_d = BAD_WORD;
                    end
                    err_d   = 1'b1;
                    dhit_d  = 1'b1;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    state_d = DONE;
                end
            end

            IACC: begin
                ren_d = 1'b1;
                if (ram_ready) begin
                    iload_d = ram_load;
                    ihit_d  = 1'b1;
                    ren_d   = 1'b0;
                    state_d = DONE;
                end else if (expired_c) begin
                    iload_d = BAD_WORD;
                    err_d   = 1'b1;
                    ihit_d  = 1'b1;
                    ren_d   = 1'b0;
                    state_d = DONE;
                end
            end

            DONE: begin
                // Requests ignored here so a held request is not re-issued.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            req_q   <= '0;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            ihit_q  <= ihit_d;
            dhit_q  <= dhit_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
        end
    end

    assign ihit      = ihit_q;
    assign dhit      = dhit_q;
    assign iload     = iload_q;
    assign dload     = dload_q;
    assign ram_REN   = ren_q;
    assign ram_WEN   = wen_q;
    assign ram_addr  = req_q.addr;
    assign ram_store = req_q.wdata;
    assign err       = err_q;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Bench for pipeline_mem_arbiter: directed scenarios plus random transactions
// checked against a transaction-level model (memory map, latency rules, sticky err,
// optional fetch buffer).
module tb_pipeline_mem_arbiter;

    localparam int          TO  = 8;
    localparam logic [31:0] BAD = 32'hBAD1BAD1;
`ifdef PIPELINE_MEM_ARBITER_IBUF_EN
    localparam bit IBUF = 1'b1;
`else
    localparam bit IBUF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dhit;
    logic [31:0] dload;
    logic        ram_REN;
    logic        ram_WEN;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load;
    logic        ram_ready;
    logic        err;

    pipeline_mem_arbiter #(.TIMEOUT(TO)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .ihit      (ihit),
        .iload     (iload),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dhit      (dhit),
        .dload     (dload),
        .ram_REN   (ram_REN),
        .ram_WEN   (ram_WEN),
        .ram_addr  (ram_addr),
        .ram_store (ram_store),
        .ram_load  (ram_load),
        .ram_ready (ram_ready),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // RAM contents as seen by the bench's RAM, and as the model expects them.
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] m_mem   [logic [31:0]];
    logic [31:0] exp_iload, exp_dload;
    bit          m_err;
    bit          m_buf_v;
    logic [31:0] m_buf_a, m_buf_d;

    logic [31:0] pool [6] = '{32'h40, 32'h44, 32'h48, 32'h100, 32'h200, 32'h204};

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h13579BDF;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return m_mem.exists(a) ? m_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One transaction from IDLE. kind: 0 fetch, 1 data read, 2 data write, 3 read+write.
    // delay: access cycles before ram_ready (0 = first strobe cycle), <0 = never.
    task automatic txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                       input int delay);
        bit          is_d, is_wr, buf_hit, timed_out, got_i, got_d;
        logic [31:0] exp_val, hit_iload, hit_dload;
        logic        hit_err;
        int          exp_lat, exp_strobes, cyc, hit_cyc, strobes, bad;

        is_d        = (kind != 0);
        is_wr       = (kind >= 2);
        buf_hit     = IBUF && !is_d && m_buf_v && (m_buf_a == addr);
        timed_out   = !buf_hit && (delay < 0 || delay >= TO);
        exp_lat     = buf_hit ? 1 : (timed_out ? TO + 1 : delay + 2);
        exp_strobes = buf_hit ? 0 : (timed_out ? TO : delay + 1);
        exp_val     = buf_hit ? m_buf_d : (timed_out ? BAD : model_rd(addr));

        iREN   = !is_d;
        iaddr  = addr;
        dREN   = (kind == 1) || (kind == 3);
        dWEN   = is_wr;
        daddr  = addr;
        dstore = wdata;
        ram_ready = 1'b0;
        cyc = 0; hit_cyc = -1; strobes = 0; bad = 0; got_i = 0; got_d = 0;
        hit_iload = 'x; hit_dload = 'x; hit_err = 1'bx;

        while (hit_cyc < 0 && cyc < 40) begin
            step();
            cyc++;
            ram_ready = 1'b0;
            if (ihit && dhit) bad++;
            if (ihit || dhit) begin
                hit_cyc   = cyc;
                got_i     = ihit;
                got_d     = dhit;
                hit_iload = iload;
                hit_dload = dload;
                hit_err   = err;
                iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
                if (ram_REN || ram_WEN) bad++;
            end else if (ram_REN || ram_WEN) begin
                if (ram_REN !== !is_wr || ram_WEN !== is_wr || ram_addr !== addr) bad++;
                if (is_wr && ram_store !== wdata) bad++;
                if (strobes == delay) begin
                    ram_ready = 1'b1;
                    ram_load  = ram_rd(ram_addr);
                    if (ram_WEN) ram_mem[ram_addr] = ram_store;
                end
                strobes++;
            end
        end

        // Model update.
        if (timed_out) m_err = 1'b1;
        if (!is_d) exp_iload = exp_val;
        else if (!is_wr) exp_dload = exp_val;
        if (is_wr && !timed_out) m_mem[addr] = wdata;
        if (timed_out) m_buf_v = 1'b0;
        else if (!is_d && !buf_hit) begin
            m_buf_v = 1'b1; m_buf_a = addr; m_buf_d = exp_val;
        end else if (is_wr && addr == m_buf_a) m_buf_v = 1'b0;

        check("txn_latency",  32'(hit_cyc), 32'(exp_lat));
        check("txn_ihit",     32'(got_i), 32'(!is_d));
        check("txn_dhit",     32'(got_d), 32'(is_d));
        check("txn_strobes",  32'(strobes), 32'(exp_strobes));
        check("txn_protocol", 32'(bad), 32'd0);
        check("txn_iload",    hit_iload, exp_iload);
        check("txn_dload",    hit_dload, exp_dload);
        check("txn_err",      32'(hit_err), 32'(m_err));
        step();
        check("txn_hit_pulse", 32'(ihit | dhit), 32'd0);
    endtask

    initial begin
        int          cyc, d_cyc, i_cyc, both, kind, dly, r;
        bit          first_set, ib_hit;
        logic        first_ren;
        logic [31:0] first_addr, exp_d, exp_i, got_dl, got_il, a;

        nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ram_load = '0; ram_ready = 1'b0;
        m_err = 1'b0; m_buf_v = 1'b0; m_buf_a = '0; m_buf_d = '0;
        exp_iload = '0; exp_dload = '0;

        // Reset state.
        step(); step(); step();
        check("rst_ihit", 32'(ihit), 32'd0);
        check("rst_dhit", 32'(dhit), 32'd0);
        check("rst_ram_REN", 32'(ram_REN), 32'd0);
        check("rst_ram_WEN", 32'(ram_WEN), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_iload", iload, 32'd0);
        check("rst_dload", dload, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_store", ram_store, 32'd0);
        nRST = 1'b1;
        step();

        // Fetch 0x40, RAM ready one cycle after strobe.
        ram_mem[32'h40] = 32'h8C220004;
        m_mem[32'h40]   = 32'h8C220004;
        txn(0, 32'h40, 32'h0, 1);

        // Data and fetch requested in the same cycle.
        ib_hit = IBUF && m_buf_v && (m_buf_a == 32'h44);
        exp_d  = model_rd(32'h100);
        exp_i  = ib_hit ? m_buf_d : model_rd(32'h44);
        dREN = 1'b1; daddr = 32'h100; iREN = 1'b1; iaddr = 32'h44;
        cyc = 0; d_cyc = -1; i_cyc = -1; both = 0; first_set = 0;
        first_addr = 'x; first_ren = 1'bx; got_dl = 'x; got_il = 'x;
        while ((d_cyc < 0 || i_cyc < 0) && cyc < 30) begin
            step();
            cyc++;
            ram_ready = 1'b0;
            if (ihit && dhit) both++;
            if (dhit) begin d_cyc = cyc; got_dl = dload; dREN = 1'b0; end
            if (ihit) begin i_cyc = cyc; got_il = iload; iREN = 1'b0; end
            if (!ihit && !dhit && (ram_REN || ram_WEN)) begin
                if (!first_set) begin
                    first_set = 1; first_addr = ram_addr; first_ren = ram_REN;
                end
                ram_ready = 1'b1;
                ram_load  = ram_rd(ram_addr);
            end
        end
        step();
        check("dual_first_addr", first_addr, 32'h100);
        check("dual_first_ren", 32'(first_ren), 32'd1);
        check("dual_dhit_cycle", 32'(d_cyc), 32'd2);
        check("dual_ihit_cycle", 32'(i_cyc), ib_hit ? 32'd4 : 32'd5);
        check("dual_both_hits", 32'(both), 32'd0);
        check("dual_dload", got_dl, exp_d);
        check("dual_iload", got_il, exp_i);
        exp_dload = exp_d;
        exp_iload = exp_i;
        if (!ib_hit) begin m_buf_v = 1'b1; m_buf_a = 32'h44; m_buf_d = exp_i; end

        // Writes, read-back, read+write collision, ready-on-last-cycle, timeout.
        txn(2, 32'h200, 32'hDEADBEEF, 0);
        txn(1, 32'h200, 32'h0, 0);
        txn(3, 32'h204, 32'h12345678, 2);
        txn(1, 32'h204, 32'h0, 3);
        txn(0, 32'h48, 32'h0, TO - 1);
        txn(1, 32'h104, 32'h0, -1);
        txn(0, 32'h4C, 32'h0, -1);

        // Repeated fetch, aliasing write, re-fetch.
        txn(0, 32'h40, 32'h0, 0);
        txn(0, 32'h40, 32'h0, 0);
        txn(2, 32'h40, 32'hCAFEF00D, 1);
        txn(0, 32'h40, 32'h0, 0);

        // Reset asserted in the middle of a data access.
        dREN = 1'b1; daddr = 32'h300;
        step();
        check("midrst_ren_before", 32'(ram_REN), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check("midrst_ram_REN", 32'(ram_REN), 32'd0);
        check("midrst_ram_WEN", 32'(ram_WEN), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_dload", dload, 32'd0);
        dREN = 1'b0;
        step();
        check("midrst_dhit_a", 32'(dhit), 32'd0);
        step();
        check("midrst_dhit_b", 32'(dhit), 32'd0);
        nRST = 1'b1;
        m_err = 1'b0; m_buf_v = 1'b0; exp_iload = '0; exp_dload = '0;
        step();
        txn(1, 32'h300, 32'h0, 1);
        txn(0, 32'h40, 32'h0, 2);

        // Random transactions.
        for (int k = 0; k < 60; k++) begin
            kind = int'($urandom_range(0, 3));
            a    = pool[$urandom_range(0, 5)];
            r    = int'($urandom_range(0, 9));
            if (r <= 5) dly = r;
            else if (r <= 7) dly = int'($urandom_range(0, 3));
            else if (r == 8) dly = TO - 1;
            else dly = -1;
            txn(kind, a, $urandom, dly);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
